// File: rtl/cache_pkg.sv
// Shared cache definitions: line geometry, line type and icache FSM states.
// Also provides a word-select helper for 32-bit words within a 512-bit line.
package cache_pkg;

    localparam int ADDR_WIDTH      = 64;
    localparam int LINE_BYTES      = 64;
    localparam int LINE_DATA_WIDTH = 512;
    localparam int LINE_ADDR_WIDTH = ADDR_WIDTH - $clog2(LINE_BYTES);
    localparam int INST_WIDTH      = 32;

    typedef logic [LINE_DATA_WIDTH-1:0] line_t;

    typedef enum logic [1:0] {
        IDLE,
        LOOKUP,
        MISS_REQ,
        FILL_RESP
    } icache_state_t;

    function automatic logic [INST_WIDTH-1:0] line_word(
        input line_t      line,
        input logic [3:0] word
    );
        return line[{word, 5'd0} +: INST_WIDTH];
    endfunction

endpackage

// File: rtl/icache_direct_mapped_if.sv
// Fetch, response and arbiter-port signals of the instruction cache.
// slave: cache side. master: fetch stage plus arbiter side.
interface icache_direct_mapped_if;
    import cache_pkg::*;

    logic                       fetch_valid;
    logic [ADDR_WIDTH-1:0]      fetch_addr;
    logic                       fetch_ready;
    logic                       flush;
    logic                       resp_valid;
    logic [INST_WIDTH-1:0]      resp_inst;
    logic [ADDR_WIDTH-1:0]      resp_addr;
    logic                       mem_req;
    logic [LINE_ADDR_WIDTH-1:0] mem_line_addr;
    logic                       mem_reqack;
    line_t                      mem_data_in;
    logic                       mem_comp;

    modport slave (
        input  fetch_valid, fetch_addr, flush,
        input  mem_reqack, mem_data_in, mem_comp,
        output fetch_ready, resp_valid, resp_inst, resp_addr,
        output mem_req, mem_line_addr
    );

    modport master (
        output fetch_valid, fetch_addr, flush,
        output mem_reqack, mem_data_in, mem_comp,
        input  fetch_ready, resp_valid, resp_inst, resp_addr,
        input  mem_req, mem_line_addr
    );

endinterface

// File: rtl/icache_line_store.sv
// Valid/tag/data arrays of the icache with registered (SRAM-style) read.
// Ports: rd_en/rd_idx -> rd_valid/rd_tag/rd_data next cycle; wr_* single write; inval_all.
module icache_line_store
    import cache_pkg::*;
#(
    parameter int NUM_SETS = 64,
    parameter int TAG_BITS = 52,
    parameter int IDX_BITS = $clog2(NUM_SETS)
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                rd_en,
    input  logic [IDX_BITS-1:0] rd_idx,
    output logic                rd_valid,
    output logic [TAG_BITS-1:0] rd_tag,
    output line_t               rd_data,
    input  logic                wr_en,
    input  logic [IDX_BITS-1:0] wr_idx,
    input  logic [TAG_BITS-1:0] wr_tag,
    input  line_t               wr_data,
    input  logic                inval_all
);

    logic [NUM_SETS-1:0] valid_q, valid_d;
    logic [TAG_BITS-1:0] tag_mem [NUM_SETS];
    line_t               data_mem [NUM_SETS];

    logic                rd_valid_q;
    logic [TAG_BITS-1:0] rd_tag_q;
    line_t               rd_data_q;

    always_comb begin
        valid_d = valid_q;
        if (inval_all) begin
            valid_d = '0;
        end else if (wr_en) begin
            valid_d[wr_idx] = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            valid_q    <= '0;
            rd_valid_q <= 1'b0;
        end else begin
            valid_q <= valid_d;
            if (rd_en) begin
                rd_valid_q <= valid_q[rd_idx];
            end
        end
    end

    // Tag/data behave like SRAM macros: no reset, contents gated by valid.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            tag_mem[wr_idx]  <= wr_tag;
            data_mem[wr_idx] <= wr_data;
        end
        if (rd_en) begin
            rd_tag_q  <= tag_mem[rd_idx];
            rd_data_q <= data_mem[rd_idx];
        end
    end

    assign rd_valid = rd_valid_q;
    assign rd_tag   = rd_tag_q;
    assign rd_data  = rd_data_q;

endmodule

// File: rtl/icache_direct_mapped.sv
// Direct-mapped L1 instruction cache: 1-cycle hits, single outstanding line miss.
// Ports: clk, reset (sync, active-high), bus (fetch/resp/flush and arbiter line port).
module icache_direct_mapped #(
    parameter int ADDR_WIDTH = cache_pkg::ADDR_WIDTH,
    parameter int LINE_BYTES = cache_pkg::LINE_BYTES,
    parameter int NUM_SETS   = 64
) (
    input  logic                   clk,
    input  logic                   reset,
    icache_direct_mapped_if.slave  bus
);
    import cache_pkg::*;

    localparam int OFF_BITS = $clog2(LINE_BYTES);
    localparam int IDX_BITS = $clog2(NUM_SETS);
    localparam int TAG_BITS = ADDR_WIDTH - OFF_BITS - IDX_BITS;

    icache_state_t         state_q, state_d;
    logic [ADDR_WIDTH-1:0] addr_q, addr_d;
    logic                  flush_pending_q, flush_pending_d;
    logic [INST_WIDTH-1:0] fill_word_q, fill_word_d;

    logic                  rd_en;
    logic                  rd_valid;
    logic [TAG_BITS-1:0]   rd_tag;
    line_t                 rd_data;
    logic                  wr_en;
    logic                  inval_all;
    logic                  hit;

    logic                  fetch_ready;
    logic                  resp_valid;
    logic [INST_WIDTH-1:0] resp_inst;
    logic                  mem_req;

    // The arbiter acknowledge is informational; progress keys off mem_comp.
    logic unused_ok;
    assign unused_ok = bus.mem_reqack;

    icache_line_store #(
        .NUM_SETS (NUM_SETS),
        .TAG_BITS (TAG_BITS),
        .IDX_BITS (IDX_BITS)
    ) u_store (
        .clk       (clk),
        .reset     (reset),
        .rd_en     (rd_en),
        .rd_idx    (bus.fetch_addr[OFF_BITS +: IDX_BITS]),
        .rd_valid  (rd_valid),
        .rd_tag    (rd_tag),
        .rd_data   (rd_data),
        .wr_en     (wr_en),
        .wr_idx    (addr_q[OFF_BITS +: IDX_BITS]),
        .wr_tag    (addr_q[ADDR_WIDTH-1 -: TAG_BITS]),
        .wr_data   (bus.mem_data_in),
        .inval_all (inval_all)
    );

    assign hit = rd_valid && (rd_tag == addr_q[ADDR_WIDTH-1 -: TAG_BITS]);

    always_comb begin
        state_d         = state_q;
        addr_d          = addr_q;
        flush_pending_d = flush_pending_q;
        fill_word_d     = fill_word_q;
        fetch_ready     = 1'b0;
        resp_valid      = 1'b0;
        resp_inst       = '0;
        mem_req         = 1'b0;
        rd_en           = 1'b0;
        wr_en           = 1'b0;
        inval_all       = 1'b0;

        unique case (state_q)
            IDLE: begin
                // A flush (new or deferred) takes the whole cycle.
                if (bus.flush || flush_pending_q) begin
                    inval_all       = 1'b1;
                    flush_pending_d = 1'b0;
                end else begin
                    fetch_ready = !reset;
                    if (bus.fetch_valid && fetch_ready) begin
                        addr_d  = bus.fetch_addr;
                        rd_en   = 1'b1;
                        state_d = LOOKUP;
                    end
                end
            end
            LOOKUP: begin
                if (bus.flush) begin
                    flush_pending_d = 1'b1;
                end
                if (hit) begin
                    resp_valid  = 1'b1;
                    resp_inst   = line_word(rd_data, addr_q[5:2]);
                    fetch_ready = !bus.flush && !flush_pending_q && !reset;
                    if (bus.fetch_valid && fetch_ready) begin
                        addr_d  = bus.fetch_addr;
                        rd_en   = 1'b1;
                        state_d = LOOKUP;
                    end else begin
                        state_d = IDLE;
                    end
                end else begin
                    state_d = MISS_REQ;
                end
            end
            MISS_REQ: begin
                if (bus.flush) begin
                    flush_pending_d = 1'b1;
                end
                // Drop the request in the completion cycle so the arbiter
                // never sees a second request for this line.
                mem_req = !bus.mem_comp;
                if (bus.mem_comp) begin
                    wr_en       = 1'b1;
                    fill_word_d = line_word(bus.mem_data_in, addr_q[5:2]);
                    state_d     = FILL_RESP;
                end
            end
            FILL_RESP: begin
                if (bus.flush) begin
                    flush_pending_d = 1'b1;
                end
                resp_valid = 1'b1;
                resp_inst  = fill_word_q;
                state_d    = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q         <= IDLE;
            addr_q          <= '0;
            flush_pending_q <= 1'b0;
            fill_word_q     <= '0;
        end else begin
            state_q         <= state_d;
            addr_q          <= addr_d;
            flush_pending_q <= flush_pending_d;
            fill_word_q     <= fill_word_d;
        end
    end

    assign bus.fetch_ready   = fetch_ready;
    assign bus.resp_valid    = resp_valid;
    assign bus.resp_inst     = resp_inst;
    assign bus.resp_addr     = resp_valid ? addr_q : '0;
    assign bus.mem_req       = mem_req;
    assign bus.mem_line_addr = addr_q[ADDR_WIDTH-1:OFF_BITS];

endmodule

// File: tb/tb_icache_direct_mapped.sv
// Self-checking bench for icache_direct_mapped with a scoreboard and arbiter model.
// Expected responses and miss line addresses are queued at accept time.
module tb_icache_direct_mapped;

    localparam int LAT = 4;

    typedef struct {
        logic [63:0] addr;
        logic [31:0] inst;
    } exp_t;

    logic clk;
    logic reset;

    icache_direct_mapped_if bus();

    icache_direct_mapped dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    int   n_checks;
    int   n_errors;
    int   mreq_cnt;
    int   stray_req;
    int   stray_ack;
    bit   arb_auto;
    exp_t resp_q[$];
    logic [57:0] miss_q[$];

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end

    task automatic check(input string tag, input logic [63:0] got,
                         input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic logic [511:0] line_data(input logic [57:0] la);
        logic [511:0] l;
        for (int w = 0; w < 16; w++) begin
            if (la == 58'h40 && w == 0) begin
                l[w*32 +: 32] = 32'hDEADBEEF;
            end else begin
                l[w*32 +: 32] = {16'hC0DE, la[11:0], 4'(w)};
            end
        end
        return l;
    endfunction

    function automatic logic [31:0] exp_word(input logic [63:0] a);
        logic [511:0] l;
        l = line_data(a[63:6]);
        return l[a[5:2]*32 +: 32];
    endfunction

    // Arbiter model: serves requests after LAT cycles, or a stray comp.
    initial begin
        logic [57:0] la;
        bus.mem_comp    = 1'b0;
        bus.mem_data_in = '0;
        bus.mem_reqack  = 1'b0;
        stray_ack       = 0;
        forever begin
            @(negedge clk);
            bus.mem_reqack = 1'b0;
            if (stray_req != stray_ack) begin
                bus.mem_data_in = {16{32'h5A5A5A5A}};
                bus.mem_comp    = 1'b1;
                @(negedge clk);
                bus.mem_comp = 1'b0;
                stray_ack    = stray_req;
            end else if (arb_auto && !reset && bus.mem_req) begin
                la = bus.mem_line_addr;
                mreq_cnt++;
                if (miss_q.size() == 0) begin
                    check("mreq_unexpected", 64'(la), 64'h0);
                end else begin
                    check("mreq_line", 64'(la), 64'(miss_q.pop_front()));
                end
                bus.mem_reqack = 1'b1;
                for (int i = 0; i < LAT; i++) begin
                    @(negedge clk);
                    bus.mem_reqack = 1'b0;
                    check("mreq_hold", {5'd0, bus.mem_req, bus.mem_line_addr},
                          {5'd0, 1'b1, la});
                end
                bus.mem_data_in = line_data(la);
                bus.mem_comp    = 1'b1;
                #1;
                check("mreq_drop", 64'(bus.mem_req), 64'h0);
                @(negedge clk);
                bus.mem_comp = 1'b0;
                check("fill_resp_cycle", 64'(bus.resp_valid), 64'h1);
            end
        end
    end

    // Response monitor: every pulse must match the head of the scoreboard.
    always @(negedge clk) begin
        if (!reset && bus.resp_valid) begin
            if (resp_q.size() == 0) begin
                check("resp_unexpected", bus.resp_addr, 64'hFFFF_FFFF_FFFF_FFFF);
            end else begin
                exp_t e;
                e = resp_q.pop_front();
                check("resp_inst", 64'(bus.resp_inst), 64'(e.inst));
                check("resp_addr", bus.resp_addr, e.addr);
            end
        end
    end

    // Called at a negedge; returns at the negedge after acceptance.
    task automatic do_fetch(input logic [63:0] a, input bit miss, input bit push);
        bit ok;
        ok = 1'b0;
        bus.fetch_valid = 1'b1;
        bus.fetch_addr  = a;
        for (int i = 0; i < 200; i++) begin
            #4;
            if (bus.fetch_ready) begin
                ok = 1'b1;
                if (push) begin
                    exp_t e;
                    e.addr = a;
                    e.inst = exp_word(a);
                    resp_q.push_back(e);
                end
                if (miss) miss_q.push_back(a[63:6]);
                @(negedge clk);
                break;
            end
            @(negedge clk);
        end
        bus.fetch_valid = 1'b0;
        if (!ok) check("fetch_timeout", 64'h0, 64'h1);
    endtask

    task automatic drain();
        for (int i = 0; i < 300; i++) begin
            if (resp_q.size() == 0 && miss_q.size() == 0) break;
            @(negedge clk);
        end
        check("drain", 64'(resp_q.size() + miss_q.size()), 64'h0);
        @(negedge clk);
    endtask

    task automatic wait_mem_req(input string tag);
        bit found;
        found = 1'b0;
        for (int i = 0; i < 50; i++) begin
            if (bus.mem_req) begin
                found = 1'b1;
                break;
            end
            @(negedge clk);
        end
        check(tag, 64'(found), 64'h1);
    endtask

    initial begin
        int base;
        bit found;
        n_checks = 0;
        n_errors = 0;
        mreq_cnt = 0;
        stray_req = 0;
        arb_auto = 1'b1;
        reset = 1'b1;
        bus.fetch_valid = 1'b0;
        bus.fetch_addr  = '0;
        bus.flush       = 1'b0;

        repeat (3) @(negedge clk);
        check("rst_fetch_ready", 64'(bus.fetch_ready), 64'h0);
        check("rst_mem_req", 64'(bus.mem_req), 64'h0);
        check("rst_resp_valid", 64'(bus.resp_valid), 64'h0);
        check("rst_resp_inst", 64'(bus.resp_inst), 64'h0);
        check("rst_resp_addr", bus.resp_addr, 64'h0);
        reset = 1'b0;
        @(negedge clk);
        check("idle_ready", 64'(bus.fetch_ready), 64'h1);

        // 1: cold miss
        do_fetch(64'h1000, 1'b1, 1'b1);
        drain();

        // 2: streaming hits, one response per cycle
        base = mreq_cnt;
        do_fetch(64'h1004, 1'b0, 1'b1);
        check("stream_resp1", 64'(bus.resp_valid), 64'h1);
        do_fetch(64'h1008, 1'b0, 1'b1);
        check("stream_resp2", 64'(bus.resp_valid), 64'h1);
        do_fetch(64'h100C, 1'b0, 1'b1);
        check("stream_resp3", 64'(bus.resp_valid), 64'h1);
        drain();
        check("stream_no_mreq", 64'(mreq_cnt - base), 64'h0);

        // 3: conflict in set 0
        do_fetch(64'h2000, 1'b1, 1'b1);
        drain();
        do_fetch(64'h2010, 1'b0, 1'b1);
        drain();
        do_fetch(64'h1000, 1'b1, 1'b1);
        drain();

        // 4: flush during a miss
        do_fetch(64'h3000, 1'b1, 1'b1);
        wait_mem_req("t4_mem_req");
        bus.flush = 1'b1;
        @(negedge clk);
        bus.flush = 1'b0;
        found = 1'b0;
        for (int i = 0; i < 100; i++) begin
            if (bus.resp_valid) begin
                found = 1'b1;
                break;
            end
            @(negedge clk);
        end
        check("t4_resp_seen", 64'(found), 64'h1);
        @(negedge clk);
        check("t4_idle_ready0", 64'(bus.fetch_ready), 64'h0);
        @(negedge clk);
        check("t4_idle_ready1", 64'(bus.fetch_ready), 64'h1);
        do_fetch(64'h3000, 1'b1, 1'b1);
        drain();

        // 5: reset mid-miss
        do_fetch(64'h1000, 1'b1, 1'b1);
        drain();
        do_fetch(64'h1004, 1'b0, 1'b1);
        drain();
        arb_auto = 1'b0;
        do_fetch(64'h5000, 1'b0, 1'b0);
        wait_mem_req("t5_mem_req");
        check("t5_line", 64'(bus.mem_line_addr), 64'h140);
        reset = 1'b1;
        @(negedge clk);
        check("t5_mem_req", 64'(bus.mem_req), 64'h0);
        check("t5_resp_valid", 64'(bus.resp_valid), 64'h0);
        check("t5_ready", 64'(bus.fetch_ready), 64'h0);
        reset = 1'b0;
        arb_auto = 1'b1;
        repeat (2) @(negedge clk);
        do_fetch(64'h1000, 1'b1, 1'b1);
        drain();

        // 6: flush beats fetch in IDLE; stray comp writes nothing
        bus.flush       = 1'b1;
        bus.fetch_valid = 1'b1;
        bus.fetch_addr  = 64'h1000;
        #4;
        check("t6_ready", 64'(bus.fetch_ready), 64'h0);
        @(negedge clk);
        bus.flush       = 1'b0;
        bus.fetch_valid = 1'b0;
        stray_req++;
        repeat (4) @(negedge clk);
        check("t6_stray_done", 64'(stray_ack), 64'(stray_req));
        do_fetch(64'h1000, 1'b1, 1'b1);
        drain();
        do_fetch(64'h103C, 1'b0, 1'b1);
        drain();

        repeat (5) @(negedge clk);
        check("end_queues", 64'(resp_q.size() + miss_q.size()), 64'h0);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
